cpuclk_switch_sched: RTL and testbench

//  Scheduler for the CPU clock switch: decides when the CPU runs on the high-speed

---
 rtl/cpuclk_switch_sched.sv | 143 ++++++++++++++
 tb/tb_cpuclk_switch_sched.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpuclk_switch_sched.sv
// CPU clock switch scheduler: chooses HS/LS operation and the divide ratio, sequencing
// every change through LS, with hold-off hysteresis and a sticky ack timeout.
module cpuclk_switch_sched #(
    parameter int unsigned HOLD_CYCLES = 2,
    parameter int unsigned TIMEOUT     = 15,
    parameter int unsigned CW          = 4
) (
    input  logic       lsclk_in,
    input  logic       rst_b,
    input  logic       turbo_en,
    input  logic       ls_req,
    input  logic [1:0] div_cfg,
    input  logic       div_cfg_wr,
    input  logic       err_clr,
    input  logic       hs_ack,
    input  logic       ls_ack,
    output logic       hsclk_sel,
    output logic [1:0] cpuclk_div_sel,
    output logic       ls_grant,
    output logic       switching,
    output logic       timeout_err
);

    typedef enum logic [2:0] {LS_RUN, GO_HS, HS_RUN, GO_LS, HOLD} state_t;

    localparam logic [CW:0]   TMO_LIM   = (CW+1)'(TIMEOUT);
    localparam logic [CW-1:0] HOLD_INIT = CW'(HOLD_CYCLES);

    state_t        state, state_nx;
    logic          hs_meta, hs_ack_s;
    logic [CW-1:0] tmo, tmo_nx, hold, hold_nx;
    logic [CW:0]   tmo_inc;
    logic          err_set;
    logic          sel_q;
    logic [1:0]    div_q, div_nx, pend_div, pend_div_nx;
    logic          pend, pend_nx;
    logic          div_window;

    assign tmo_inc = {1'b0, tmo} + (CW+1)'(1);

    always_comb begin
        state_nx = state;
        tmo_nx   = tmo;
        hold_nx  = hold;
        err_set  = 1'b0;
        case (state)
            LS_RUN: begin
                if (turbo_en && !ls_req && !pend && ls_ack && !timeout_err) begin
                    state_nx = GO_HS;
                    tmo_nx   = '0;
                end
            end
            GO_HS: begin
                tmo_nx = tmo_inc[CW-1:0];
                if (hs_ack_s) begin
                    state_nx = HS_RUN;
                end else if (ls_req || !turbo_en || pend) begin
                    state_nx = GO_LS;
                    tmo_nx   = '0;
                end else if (tmo_inc == TMO_LIM) begin
                    err_set  = 1'b1;
                    state_nx = GO_LS;
                    tmo_nx   = '0;
                end
            end
            HS_RUN: begin
                if (ls_req || !turbo_en || div_cfg_wr || pend) begin
                    state_nx = GO_LS;
                    tmo_nx   = '0;
                end
            end
            GO_LS: begin
                if (ls_ack && !hs_ack_s) begin
                    state_nx = HOLD;
                    hold_nx  = HOLD_INIT;
                end else begin
                    // keeps flagging while stuck so err_clr cannot mask a dead switch
                    if (tmo_inc >= TMO_LIM) err_set = 1'b1;
                    if (tmo_inc <= TMO_LIM) tmo_nx = tmo_inc[CW-1:0];
                end
            end
            HOLD: begin
                if (ls_req)            hold_nx  = HOLD_INIT;
                else if (hold == '0)   state_nx = LS_RUN;
                else                   hold_nx  = hold - CW'(1);
            end
            default: state_nx = LS_RUN;
        endcase
    end

    // divider may only move while the CPU is provably on LS
    assign div_window = (state == LS_RUN || state == HOLD) && ls_ack && !hs_ack_s;

    always_comb begin
        div_nx      = div_q;
        pend_nx     = pend;
        pend_div_nx = pend_div;
        if (div_window) begin
            if (div_cfg_wr) begin
                div_nx  = div_cfg;
                pend_nx = 1'b0;
            end else if (pend) begin
                div_nx  = pend_div;
                pend_nx = 1'b0;
            end
        end else if (div_cfg_wr) begin
            pend_nx     = 1'b1;
            pend_div_nx = div_cfg;
        end
    end

    always_ff @(posedge lsclk_in or negedge rst_b) begin
        if (!rst_b) begin
            state       <= LS_RUN;
            hs_meta     <= 1'b0;
            hs_ack_s    <= 1'b0;
            tmo         <= '0;
            hold        <= '0;
            sel_q       <= 1'b0;
            div_q       <= '0;
            pend        <= 1'b0;
            pend_div    <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nx;
            hs_meta     <= hs_ack;
            hs_ack_s    <= hs_meta;
            tmo         <= tmo_nx;
            hold        <= hold_nx;
            sel_q       <= (state_nx == GO_HS) || (state_nx == HS_RUN);
            div_q       <= div_nx;
            pend        <= pend_nx;
            pend_div    <= pend_div_nx;
            timeout_err <= err_set ? 1'b1 : (err_clr ? 1'b0 : timeout_err);
        end
    end

    assign hsclk_sel      = sel_q;
    assign cpuclk_div_sel = div_q;
    assign ls_grant       = ls_ack && !sel_q && (state == LS_RUN || state == HOLD);
    assign switching      = (state == GO_HS) || (state == GO_LS);

endmodule

// File: tb/tb_cpuclk_switch_sched.sv
// Bench for cpuclk_switch_sched: directed scenarios plus randomized traffic against an
// emulated clock switch, all outputs checked every cycle against a behavioural model.
module tb_cpuclk_switch_sched;

    localparam int HC = 2;
    localparam int TO = 15;

    localparam int M_LS = 0, M_UP = 1, M_HS = 2, M_DN = 3, M_HOLD = 4;

    logic       lsclk_in = 1'b0;
    logic       rst_b = 1'b0;
    logic       turbo_en = 1'b0, ls_req = 1'b0, div_cfg_wr = 1'b0, err_clr = 1'b0;
    logic [1:0] div_cfg = 2'd0;
    logic       hs_ack = 1'b0, ls_ack = 1'b0;
    logic       hsclk_sel, ls_grant, switching, timeout_err;
    logic [1:0] cpuclk_div_sel;

    always #5 lsclk_in = ~lsclk_in;

    cpuclk_switch_sched #(.HOLD_CYCLES(HC), .TIMEOUT(TO), .CW(4)) dut (
        .lsclk_in(lsclk_in), .rst_b(rst_b), .turbo_en(turbo_en), .ls_req(ls_req),
        .div_cfg(div_cfg), .div_cfg_wr(div_cfg_wr), .err_clr(err_clr),
        .hs_ack(hs_ack), .ls_ack(ls_ack), .hsclk_sel(hsclk_sel),
        .cpuclk_div_sel(cpuclk_div_sel), .ls_grant(ls_grant),
        .switching(switching), .timeout_err(timeout_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- emulated clock switch ----------------
    int   hs_lat = 4, ls_lat = 1;
    bit   never_ack = 1'b0;
    logic last_sel = 1'b0;
    int   sel_age = 100;

    initial forever begin
        @(negedge lsclk_in);
        if (hsclk_sel !== last_sel) begin
            sel_age  = 0;
            last_sel = hsclk_sel;
        end else if (sel_age < 1000) begin
            sel_age++;
        end
        hs_ack = (hsclk_sel === 1'b1) && !never_ack && (sel_age >= hs_lat);
        ls_ack = (hsclk_sel === 1'b0) && (sel_age >= ls_lat);
    end

    // ---------------- behavioural model ----------------
    // mode: what the CPU clock is doing; age: cycles spent waiting for an ack;
    // quiet: consecutive request-free cycles since the LS episode ended.
    typedef struct {
        int mode; int age; int quiet; bit err; bit pend; int div; int pdiv; bit h0; bit h1;
    } model_t;

    model_t m;

    function automatic model_t model_reset();
        model_t r;
        r.mode = M_LS; r.age = 0; r.quiet = 0; r.err = 0; r.pend = 0;
        r.div = 0; r.pdiv = 0; r.h0 = 0; r.h1 = 0;
        return r;
    endfunction

    function automatic model_t step(model_t c, bit turbo, bit req, bit wr, int cfg,
                                    bit clr, bit hsa, bit lsa);
        model_t n;
        bit hs_seen, set_err, safe_ls;
        n = c;
        hs_seen = c.h1;
        set_err = 0;
        safe_ls = (c.mode == M_LS || c.mode == M_HOLD) && lsa && !hs_seen;
        if (c.mode == M_LS) begin
            if (turbo && !req && !c.pend && lsa && !c.err) begin n.mode = M_UP; n.age = 0; end
        end else if (c.mode == M_UP) begin
            if (hs_seen) n.mode = M_HS;
            else if (req || !turbo || c.pend) begin n.mode = M_DN; n.age = 0; end
            else if (c.age + 1 == TO) begin set_err = 1; n.mode = M_DN; n.age = 0; end
            else n.age = c.age + 1;
        end else if (c.mode == M_HS) begin
            if (req || !turbo || wr || c.pend) begin n.mode = M_DN; n.age = 0; end
        end else if (c.mode == M_DN) begin
            if (lsa && !hs_seen) begin n.mode = M_HOLD; n.quiet = 0; end
            else begin
                if (c.age + 1 >= TO) set_err = 1;
                if (c.age < TO) n.age = c.age + 1;
            end
        end else begin
            if (req) n.quiet = 0;
            else if (c.quiet >= HC) n.mode = M_LS;
            else n.quiet = c.quiet + 1;
        end
        n.err = set_err ? 1'b1 : (clr ? 1'b0 : c.err);
        if (safe_ls && wr) begin n.div = cfg; n.pend = 0; end
        else if (safe_ls && c.pend) begin n.div = c.pdiv; n.pend = 0; end
        else if (!safe_ls && wr) begin n.pend = 1; n.pdiv = cfg; end
        n.h1 = c.h0;
        n.h0 = hsa;
        return n;
    endfunction

    always @(posedge lsclk_in or negedge rst_b) begin
        if (!rst_b) m <= model_reset();
        else m <= step(m, turbo_en, ls_req, div_cfg_wr, int'(div_cfg), err_clr, hs_ack, ls_ack);
    end

    // ---------------- per-cycle compare ----------------
    logic       prev_sel = 1'b0;
    logic [1:0] prev_div = 2'd0;

    initial forever begin
        bit exp_sel, exp_grant, exp_sw;
        @(negedge lsclk_in);
        #2;
        exp_sel   = (m.mode == M_UP || m.mode == M_HS);
        exp_sw    = (m.mode == M_UP || m.mode == M_DN);
        exp_grant = ls_ack && !exp_sel && (m.mode == M_LS || m.mode == M_HOLD);
        chk("hsclk_sel", int'(hsclk_sel), int'(exp_sel));
        chk("cpuclk_div_sel", int'(cpuclk_div_sel), m.div);
        chk("ls_grant", int'(ls_grant), int'(exp_grant));
        chk("switching", int'(switching), int'(exp_sw));
        chk("timeout_err", int'(timeout_err), int'(m.err));
        if (rst_b && prev_sel) chk("div_stable_while_hs", int'(cpuclk_div_sel), int'(prev_div));
        prev_sel = rst_b && hsclk_sel;
        prev_div = cpuclk_div_sel;
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge lsclk_in);
            #1;
        end
    endtask

    initial begin
        int k, n;
        cyc(3);
        rst_b = 1'b1;
        chk("rst_sel", int'(hsclk_sel), 0);
        chk("rst_div", int'(cpuclk_div_sel), 0);
        chk("rst_err", int'(timeout_err), 0);
        chk("rst_switching", int'(switching), 0);
        cyc(2);

        // HS entry with a 4-cycle switch ack: 4 + 2 sync + 1 state = 7 GO_HS cycles
        turbo_en = 1'b1;
        k = 0;
        while (hsclk_sel !== 1'b1 && k < 20) begin cyc(1); k++; end
        chk("t1_sel_rise", int'(hsclk_sel), 1);
        n = 0; k = 0;
        while (switching === 1'b1 && hsclk_sel === 1'b1 && k < 30) begin n++; cyc(1); k++; end
        chk("t1_go_hs_cycles", n, 7);
        chk("t1_hs_run_sel", int'(hsclk_sel), 1);
        chk("t1_hs_run_switching", int'(switching), 0);

        // single-cycle ls_req in HS_RUN; grant spans HOLD (HC+1) plus one LS_RUN cycle
        ls_req = 1'b1;
        cyc(1);
        ls_req = 1'b0;
        chk("t2_sel_drop", int'(hsclk_sel), 0);
        k = 0;
        while (ls_grant !== 1'b1 && k < 20) begin cyc(1); k++; end
        chk("t2_grant", int'(ls_grant), 1);
        n = 0; k = 0;
        while (ls_grant === 1'b1 && k < 20) begin n++; cyc(1); k++; end
        chk("t2_grant_cycles", n, HC + 2);
        chk("t2_hs_rerequested", int'(hsclk_sel), 1);

        // divider write in HS_RUN is deferred until the switch is back on LS
        k = 0;
        while (!(hsclk_sel === 1'b1 && switching === 1'b0) && k < 30) begin cyc(1); k++; end
        chk("t3_in_hs_run", int'(hsclk_sel === 1'b1 && switching === 1'b0), 1);
        div_cfg = 2'b10;
        div_cfg_wr = 1'b1;
        cyc(1);
        div_cfg_wr = 1'b0;
        chk("t3_div_deferred", int'(cpuclk_div_sel), 0);
        k = 0;
        while (cpuclk_div_sel !== 2'b10 && k < 30) begin cyc(1); k++; end
        chk("t3_div_applied", int'(cpuclk_div_sel), 2);
        chk("t3_div_sel_low", int'(hsclk_sel), 0);

        // switch never acks HS: exactly TO cycles of GO_HS, then sticky error on LS
        never_ack = 1'b1;
        ls_req = 1'b1;
        k = 0;
        while (ls_grant !== 1'b1 && k < 40) begin cyc(1); k++; end
        chk("t4_back_to_ls", int'(ls_grant), 1);
        ls_req = 1'b0;
        k = 0;
        while (hsclk_sel !== 1'b1 && k < 20) begin cyc(1); k++; end
        chk("t4_sel_rise", int'(hsclk_sel), 1);
        n = 0; k = 0;
        while (hsclk_sel === 1'b1 && k < 40) begin n++; cyc(1); k++; end
        chk("t4_go_hs_cycles", n, TO);
        chk("t4_err_set", int'(timeout_err), 1);
        cyc(10);
        chk("t4_stays_ls", int'(hsclk_sel), 0);
        chk("t4_err_sticky", int'(timeout_err), 1);
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;
        k = 0;
        while (hsclk_sel !== 1'b1 && k < 20) begin cyc(1); k++; end
        chk("t4_retry", int'(hsclk_sel), 1);
        chk("t4_err_cleared", int'(timeout_err), 0);

        // err_clr coincides with the timeout edge: the set must win
        cyc(TO - 1);
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;
        chk("t5_set_wins", int'(timeout_err), 1);
        chk("t5_sel_low", int'(hsclk_sel), 0);

        // asynchronous reset in the middle of GO_HS
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;
        k = 0;
        while (hsclk_sel !== 1'b1 && k < 20) begin cyc(1); k++; end
        cyc(2);
        chk("t6_in_go_hs", int'(switching && hsclk_sel), 1);
        rst_b = 1'b0;
        #1;
        chk("t6_rst_sel", int'(hsclk_sel), 0);
        chk("t6_rst_div", int'(cpuclk_div_sel), 0);
        chk("t6_rst_switching", int'(switching), 0);
        cyc(2);
        rst_b = 1'b1;
        never_ack = 1'b0;

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(1);
            if (i % 200 == 0) begin
                hs_lat    = int'($urandom_range(1, 6));
                ls_lat    = int'($urandom_range(0, 3));
                never_ack = ($urandom_range(0, 5) == 0);
            end
            turbo_en   = ($urandom_range(0, 9) != 0);
            ls_req     = ($urandom_range(0, 19) == 0);
            div_cfg_wr = ($urandom_range(0, 24) == 0);
            div_cfg    = 2'($urandom_range(0, 3));
            err_clr    = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 999) == 0) begin
                rst_b = 1'b0;
                cyc(1);
                rst_b = 1'b1;
            end
        end
        turbo_en = 1'b0; ls_req = 1'b0; div_cfg_wr = 1'b0; err_clr = 1'b0;
        cyc(3);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
